ixu_branch_resolve: RTL and testbench
=====================================

Name: ixu_branch_resolve

Overview:
- Stage directly downstream of the integer-unit branch unit.
- Registers the branch unit's resolved outcome (taken, target, type) and compares it with the BTB prediction carried alongside the instruction.
- On a misprediction, raises a one-cycle redirect exception to the RCU, then holds off further reports until the pipeline flush arrives.
- Queues BTB/bimodal updates in a small FIFO toward the front end.

Parameters:
- ROB_W, 6, width of the ROB tag.
- UPD_DEPTH, 2, number of BTB update FIFO entries (power of two, ≥2).

Ports:
- cpu_clock_i  in  1  core clock.
- cpu_reset_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  pipeline flush from RCU.
- valid_i  in  1  branch-pipe instruction valid this cycle.
- rob_id_i  in  ROB_W  ROB tag of instruction.
- pc_i  in  30  word PC of instruction.
- auipc_i  in  1  instruction is AUIPC (never mispredicts).
- brnch_res_i  in  1  resolved condition (from branch unit).
- branch_type_i  in  2  00 cond, 01 call, 10 jump, 11 ret.
- excp_addr_i  in  32  resolved next PC.
- btb_vld_i  in  1  BTB hit at fetch.
- btb_target_i  in  30  predicted word target.
- btype_i  in  2  predicted type.
- bm_pred_i  in  2  bimodal counter read at fetch.
- stall_o  out  1  branch pipe must not issue (update FIFO full).
- rcu_excp_o  out  1  mispredict redirect pulse.
- rcu_rob_o  out  ROB_W  tag of mispredicted instruction.
- rcu_redirect_o  out  32  correct next PC.
- call_affirm_o  out  1  correctly predicted call pulse.
- ret_affirm_o  out  1  correctly predicted ret pulse.
- btb_upd_vld_o  out  1  BTB update valid (FIFO head).
- btb_upd_rdy_i  in  1  front end accepts update.
- btb_upd_pc_o  out  30  PC to write.
- btb_upd_target_o  out  30  target to write.
- btb_upd_type_o  out  2  type to write.
- btb_upd_bm_o  out  2  new bimodal counter.
- btb_upd_inv_o  out  1  invalidate entry (BTB hit on a non-branch, i.e. AUIPC).

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE.
- Accept condition: `acc = valid_i & !flush_i & !stall_o`.

Misprediction terms (combinational on inputs):
- `wn = !btb_vld_i & !auipc_i & (brnch_res_i | branch_type_i != 0)` (missed branch).
- `wt = btb_vld_i & {btb_target_i,2'b00} != excp_addr_i` (wrong target).
- `wty = btb_vld_i & btype_i != branch_type_i` (wrong type).
- `wb = btb_vld_i & branch_type_i == 0 & (brnch_res_i ^ bm_pred_i[1])` (wrong direction).
- `mis = wn | wt | wty | wb`.
- Exception: AUIPC with `btb_vld_i` counts as `mis` (redirect to `excp_addr_i`) and must also produce an invalidate update.

Outputs (1-cycle latency, registered):
- `rcu_excp_o` is set the cycle after `acc & mis & state==IDLE`.
- `rcu_rob_o` and `rcu_redirect_o` are captured in the same cycle and held until the next report.
- `call_affirm_o` and `ret_affirm_o` pulse after `acc & !mis & btb_vld_i` with type call or ret respectively.

State machine:
- IDLE → WAIT_FLUSH on a report.
- WAIT_FLUSH → IDLE on `flush_i`.
- In WAIT_FLUSH, accepted instructions are younger (the branch pipe is in order); no reports, no affirms, no FIFO pushes.
- `flush_i` in IDLE has no state effect.
- Reset in WAIT_FLUSH returns to IDLE.

BTB update push (on `acc`, state IDLE, not AUIPC without hit):
- Push when `mis` is set, or when `btb_vld_i & branch_type_i==0` (counter training).
- Bimodal counter:
  - Conditional branch with BTB hit: saturating update of `bm_pred_i` (inc if taken, dec if not; 11 stays 11, 00 stays 00).
  - Newly allocated conditional: 10.
  - Jumps, calls, rets: 11.
- Skip allocation when `!btb_vld_i` and a conditional branch is not taken (no push).
- Target = `excp_addr_i[31:2]`.

FIFO:
- Depth UPD_DEPTH; pop on `btb_upd_vld_o & btb_upd_rdy_i`.
- Simultaneous push and pop while full is allowed (the pop frees the slot).
- `stall_o = full & !(btb_upd_vld_o & btb_upd_rdy_i)`.
- `flush_i` does NOT clear the FIFO: updates come from already-resolved, non-speculative-relative-to-report branches.
- Pointers wrap modulo UPD_DEPTH with one extra bit for full/empty.

Decomposition:
- Shared package: branch type encodings (BT_COND/BT_CALL/BT_JUMP/BT_RET), bimodal reset constants (BM_WEAK_T=2'b10, BM_STRONG_T=2'b11), and a packed struct `btb_upd_t` {inv, pc, target, type, bm}.
- Sub-module `ixu_btb_upd_fifo`: generic UPD_DEPTH-entry FIFO of `btb_upd_t`.

Test Plan:
- Cond branch, BTB hit, bm_pred=01, brnch_res=1 → rcu_excp_o=1 next cycle, rcu_redirect_o=excp_addr_i; FIFO entry bm=10; no affirm.
- Cond branch, BTB hit, bm_pred=11, taken, target matches → no excp; FIFO entry bm=11 (saturates).
- Call, BTB hit, btype=01, target match → call_affirm_o=1 one cycle; BTB hit, target 0x100 vs excp_addr 0x204 → excp, redirect 0x204.
- Two mispredicts on consecutive cycles → only the first reported; second produces no excp/push; after flush_i, a third mispredict is reported.
- btb_upd_rdy_i=0 with pushes of 3 valid branches (UPD_DEPTH=2) → stall_o=1 after the 2nd; rdy=1 then pops in order, stall_o drops the same cycle as the pop.
- AUIPC with btb_vld_i=1 → excp, FIFO entry inv=1; assert cpu_reset_i mid-WAIT_FLUSH → all outputs 0, FIFO empty.

Source files
------------

// File: rtl/ixu_branch_resolve_pkg.sv
// Shared types and constants for the branch-resolve stage and its BTB update queue.
package ixu_branch_resolve_pkg;

    // Branch type encodings, shared by the branch unit and the BTB
    localparam logic [1:0] BT_COND = 2'b00;
    localparam logic [1:0] BT_CALL = 2'b01;
    localparam logic [1:0] BT_JUMP = 2'b10;
    localparam logic [1:0] BT_RET  = 2'b11;

    // Bimodal counter values written on allocation
    localparam logic [1:0] BM_WEAK_T   = 2'b10;
    localparam logic [1:0] BM_STRONG_T = 2'b11;

    // Counter value carried on an invalidate entry; the front end ignores it
    localparam logic [1:0] BM_INV      = 2'b00;

    // One BTB/bimodal write request toward the front end
    typedef struct packed {
        logic        inv;
        logic [29:0] pc;
        logic [29:0] target;
        logic [1:0]  br_type;
        logic [1:0]  bm;
    } btb_upd_t;

    typedef enum logic {
        ST_IDLE       = 1'b0,
        ST_WAIT_FLUSH = 1'b1
    } state_e;

    // Two-bit saturating counter step toward the resolved direction
    function automatic logic [1:0] bm_train(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ixu_btb_upd_fifo.sv
// Small FIFO of BTB update requests. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module ixu_btb_upd_fifo
    import ixu_branch_resolve_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  btb_upd_t data_i,
    input  logic     pop_i,
    output logic     vld_o,
    output logic     full_o,
    output btb_upd_t data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    btb_upd_t       mem_q [DEPTH];
    logic           empty;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign vld_o   = !empty;
    assign do_pop  = pop_i && !empty;
    // A pop in the same cycle frees the slot, so a push while full is legal then
    assign do_push = push_i && (!full_o || do_pop);
    // Head is forced to zero while empty so the outputs are clean after reset
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

    // Pointer advance on accepted push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end

endmodule

// File: rtl/ixu_branch_resolve.sv
// Branch resolve stage: checks the resolved branch against the BTB prediction,
// raises a single redirect per mispredict (then waits for the flush), affirms
// correctly predicted calls/rets and queues BTB/bimodal updates.
module ixu_branch_resolve
    import ixu_branch_resolve_pkg::*;
#(
    parameter int ROB_W     = 6,
    parameter int UPD_DEPTH = 2
) (
    input  logic             cpu_clock_i,
    input  logic             cpu_reset_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [ROB_W-1:0] rob_id_i,
    input  logic [29:0]      pc_i,
    input  logic             auipc_i,
    input  logic             brnch_res_i,
    input  logic [1:0]       branch_type_i,
    input  logic [31:0]      excp_addr_i,
    input  logic             btb_vld_i,
    input  logic [29:0]      btb_target_i,
    input  logic [1:0]       btype_i,
    input  logic [1:0]       bm_pred_i,
    output logic             stall_o,
    output logic             rcu_excp_o,
    output logic [ROB_W-1:0] rcu_rob_o,
    output logic [31:0]      rcu_redirect_o,
    output logic             call_affirm_o,
    output logic             ret_affirm_o,
    output logic             btb_upd_vld_o,
    input  logic             btb_upd_rdy_i,
    output logic [29:0]      btb_upd_pc_o,
    output logic [29:0]      btb_upd_target_o,
    output logic [1:0]       btb_upd_type_o,
    output logic [1:0]       btb_upd_bm_o,
    output logic             btb_upd_inv_o
);

    state_e           state_q, state_d;
    logic             excp_q, excp_d;
    logic [ROB_W-1:0] rob_q, rob_d;
    logic [31:0]      redirect_q, redirect_d;
    logic             call_q, call_d;
    logic             ret_q, ret_d;

    logic     acc, idle;
    logic     wn, wt, wty, wb, mis;
    logic     report;
    logic     push, pop, fifo_full;
    btb_upd_t upd_entry, upd_head;

    assign idle = (state_q == ST_IDLE);
    assign pop  = btb_upd_vld_o && btb_upd_rdy_i;
    // Full only stalls issue if the front end is not draining this cycle
    assign stall_o = fifo_full && !pop;
    assign acc  = valid_i && !flush_i && !stall_o;

    // Mispredict classification; an AUIPC that hit in the BTB is always a redirect
    always_comb begin
        wn  = !btb_vld_i && !auipc_i && (brnch_res_i || (branch_type_i != BT_COND));
        wt  = btb_vld_i && ({btb_target_i, 2'b00} != excp_addr_i);
        wty = btb_vld_i && (btype_i != branch_type_i);
        wb  = btb_vld_i && (branch_type_i == BT_COND) && (brnch_res_i ^ bm_pred_i[1]);
        if (auipc_i) mis = btb_vld_i;
        else         mis = wn || wt || wty || wb;
    end

    assign report = acc && mis && idle;

    // Update request: mispredicts allocate/repair, correct conditional hits train the counter
    always_comb begin
        upd_entry         = '0;
        upd_entry.inv     = auipc_i;
        upd_entry.pc      = pc_i;
        upd_entry.target  = excp_addr_i[31:2];
        upd_entry.br_type = branch_type_i;
        if (auipc_i)                          upd_entry.bm = BM_INV;
        else if (branch_type_i != BT_COND)    upd_entry.bm = BM_STRONG_T;
        else if (btb_vld_i)                   upd_entry.bm = bm_train(bm_pred_i, brnch_res_i);
        else                                  upd_entry.bm = BM_WEAK_T;
        push = acc && idle && !(auipc_i && !btb_vld_i) &&
               (mis || (btb_vld_i && (branch_type_i == BT_COND)));
    end

    // Next-state and registered report/affirm values
    always_comb begin
        state_d    = state_q;
        excp_d     = 1'b0;
        rob_d      = rob_q;
        redirect_d = redirect_q;
        call_d     = 1'b0;
        ret_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (report) begin
                    state_d    = ST_WAIT_FLUSH;
                    excp_d     = 1'b1;
                    rob_d      = rob_id_i;
                    redirect_d = excp_addr_i;
                end else if (acc && btb_vld_i) begin
                    call_d = (branch_type_i == BT_CALL);
                    ret_d  = (branch_type_i == BT_RET);
                end
            end
            ST_WAIT_FLUSH: begin
                if (flush_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            state_q    <= ST_IDLE;
            excp_q     <= 1'b0;
            rob_q      <= '0;
            redirect_q <= '0;
            call_q     <= 1'b0;
            ret_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            excp_q     <= excp_d;
            rob_q      <= rob_d;
            redirect_q <= redirect_d;
            call_q     <= call_d;
            ret_q      <= ret_d;
        end
    end

    ixu_btb_upd_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk_i  (cpu_clock_i),
        .rst_i  (cpu_reset_i),
        .push_i (push),
        .data_i (upd_entry),
        .pop_i  (pop),
        .vld_o  (btb_upd_vld_o),
        .full_o (fifo_full),
        .data_o (upd_head)
    );

    assign rcu_excp_o       = excp_q;
    assign rcu_rob_o        = rob_q;
    assign rcu_redirect_o   = redirect_q;
    assign call_affirm_o    = call_q;
    assign ret_affirm_o     = ret_q;
    assign btb_upd_pc_o     = upd_head.pc;
    assign btb_upd_target_o = upd_head.target;
    assign btb_upd_type_o   = upd_head.br_type;
    assign btb_upd_bm_o     = upd_head.bm;
    assign btb_upd_inv_o    = upd_head.inv;

endmodule

// File: tb/tb_ixu_branch_resolve.sv
// Directed bench for ixu_branch_resolve with a queue of expected BTB updates.
module tb_ixu_branch_resolve;
    import ixu_branch_resolve_pkg::*;

    localparam int ROB_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i, valid_i, auipc_i, brnch_res_i, btb_vld_i, btb_upd_rdy_i;
    logic [ROB_W-1:0] rob_id_i;
    logic [29:0]      pc_i, btb_target_i;
    logic [1:0]       branch_type_i, btype_i, bm_pred_i;
    logic [31:0]      excp_addr_i;
    logic             stall_o, rcu_excp_o, call_affirm_o, ret_affirm_o, btb_upd_vld_o, btb_upd_inv_o;
    logic [ROB_W-1:0] rcu_rob_o;
    logic [31:0]      rcu_redirect_o;
    logic [29:0]      btb_upd_pc_o, btb_upd_target_o;
    logic [1:0]       btb_upd_type_o, btb_upd_bm_o;

    int n_chk  = 0;
    int n_fail = 0;
    btb_upd_t exp_q[$];

    ixu_branch_resolve #(.ROB_W(ROB_W), .UPD_DEPTH(2)) dut (
        .cpu_clock_i(clk), .cpu_reset_i(rst), .flush_i(flush_i), .valid_i(valid_i),
        .rob_id_i(rob_id_i), .pc_i(pc_i), .auipc_i(auipc_i), .brnch_res_i(brnch_res_i),
        .branch_type_i(branch_type_i), .excp_addr_i(excp_addr_i), .btb_vld_i(btb_vld_i),
        .btb_target_i(btb_target_i), .btype_i(btype_i), .bm_pred_i(bm_pred_i),
        .stall_o(stall_o), .rcu_excp_o(rcu_excp_o), .rcu_rob_o(rcu_rob_o),
        .rcu_redirect_o(rcu_redirect_o), .call_affirm_o(call_affirm_o),
        .ret_affirm_o(ret_affirm_o), .btb_upd_vld_o(btb_upd_vld_o),
        .btb_upd_rdy_i(btb_upd_rdy_i), .btb_upd_pc_o(btb_upd_pc_o),
        .btb_upd_target_o(btb_upd_target_o), .btb_upd_type_o(btb_upd_type_o),
        .btb_upd_bm_o(btb_upd_bm_o), .btb_upd_inv_o(btb_upd_inv_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic btb_upd_t mk(input logic inv, input logic [29:0] pc,
                                    input logic [29:0] tgt, input logic [1:0] ty,
                                    input logic [1:0] bm);
        btb_upd_t u;
        u.inv = inv; u.pc = pc; u.target = tgt; u.br_type = ty; u.bm = bm;
        return u;
    endfunction

    task automatic drv(input logic v, input logic [ROB_W-1:0] rob, input logic [29:0] pc,
                       input logic au, input logic res, input logic [1:0] bt,
                       input logic [31:0] ea, input logic hit, input logic [29:0] tgt,
                       input logic [1:0] pbt, input logic [1:0] bm);
        valid_i = v; rob_id_i = rob; pc_i = pc; auipc_i = au; brnch_res_i = res;
        branch_type_i = bt; excp_addr_i = ea; btb_vld_i = hit; btb_target_i = tgt;
        btype_i = pbt; bm_pred_i = bm;
    endtask

    task automatic idle(input logic fl);
        drv(1'b0, '0, '0, 1'b0, 1'b0, 2'b00, '0, 1'b0, '0, 2'b00, 2'b00);
        flush_i = fl;
    endtask

    // One clock: compare any update the front end takes this cycle, then advance
    task automatic step();
        btb_upd_t e;
        @(negedge clk);
        if (btb_upd_vld_o && btb_upd_rdy_i) begin
            if (exp_q.size() == 0) begin
                chk("upd_unexpected", 64'(btb_upd_vld_o), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("upd_inv",    64'(btb_upd_inv_o),    64'(e.inv));
                chk("upd_pc",     64'(btb_upd_pc_o),     64'(e.pc));
                chk("upd_target", 64'(btb_upd_target_o), 64'(e.target));
                chk("upd_type",   64'(btb_upd_type_o),   64'(e.br_type));
                chk("upd_bm",     64'(btb_upd_bm_o),     64'(e.bm));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        btb_upd_rdy_i = 1'b1;
        idle(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_excp", 64'(rcu_excp_o), 0);
        chk("rst_rob", 64'(rcu_rob_o), 0);
        chk("rst_redirect", 64'(rcu_redirect_o), 0);
        chk("rst_call", 64'(call_affirm_o), 0);
        chk("rst_ret", 64'(ret_affirm_o), 0);
        chk("rst_upd_vld", 64'(btb_upd_vld_o), 0);
        chk("rst_stall", 64'(stall_o), 0);
        chk("rst_upd_pc", 64'(btb_upd_pc_o), 0);
        rst = 1'b0;
        step();

        // Conditional hit, counter says not-taken but branch taken
        drv(1, 6'd5, 30'h10, 0, 1, BT_COND, 32'h80, 1, 30'h20, BT_COND, 2'b01);
        exp_q.push_back(mk(0, 30'h10, 30'h20, BT_COND, 2'b10));
        step();
        chk("t1_excp", 64'(rcu_excp_o), 1);
        chk("t1_rob", 64'(rcu_rob_o), 5);
        chk("t1_redirect", 64'(rcu_redirect_o), 32'h80);
        chk("t1_call", 64'(call_affirm_o), 0);
        idle(1'b1); step();
        chk("t1_excp_pulse", 64'(rcu_excp_o), 0);
        chk("t1_rob_hold", 64'(rcu_rob_o), 5);
        chk("t1_redirect_hold", 64'(rcu_redirect_o), 32'h80);

        // Correct strongly-taken conditional: counter saturates at 11
        drv(1, 6'd6, 30'h11, 0, 1, BT_COND, 32'h84, 1, 30'h21, BT_COND, 2'b11);
        flush_i = 1'b0;
        exp_q.push_back(mk(0, 30'h11, 30'h21, BT_COND, 2'b11));
        step();
        chk("t2_excp", 64'(rcu_excp_o), 0);
        chk("t2_redirect_hold", 64'(rcu_redirect_o), 32'h80);

        // Correctly predicted call and ret
        drv(1, 6'd7, 30'h12, 0, 0, BT_CALL, 32'h400, 1, 30'h100, BT_CALL, 2'b00);
        step();
        chk("t3_call", 64'(call_affirm_o), 1);
        chk("t3_ret", 64'(ret_affirm_o), 0);
        chk("t3_excp", 64'(rcu_excp_o), 0);
        drv(1, 6'd8, 30'h13, 0, 0, BT_RET, 32'h800, 1, 30'h200, BT_RET, 2'b00);
        step();
        chk("t3r_ret", 64'(ret_affirm_o), 1);
        chk("t3r_call", 64'(call_affirm_o), 0);
        idle(1'b0); step();
        chk("t3_ret_pulse", 64'(ret_affirm_o), 0);

        // Call with wrong target: predicted 0x100, resolved 0x204
        drv(1, 6'd9, 30'h14, 0, 0, BT_CALL, 32'h204, 1, 30'h40, BT_CALL, 2'b00);
        exp_q.push_back(mk(0, 30'h14, 30'h81, BT_CALL, 2'b11));
        step();
        chk("t4_excp", 64'(rcu_excp_o), 1);
        chk("t4_rob", 64'(rcu_rob_o), 9);
        chk("t4_redirect", 64'(rcu_redirect_o), 32'h204);
        chk("t4_call", 64'(call_affirm_o), 0);
        idle(1'b1); step();
        flush_i = 1'b0;

        // Not-taken conditional with no BTB hit: nothing to report or allocate
        drv(1, 6'd10, 30'h18, 0, 0, BT_COND, 32'h64, 0, 30'h0, BT_COND, 2'b00);
        step();
        chk("t5n_excp", 64'(rcu_excp_o), 0);
        chk("t5n_upd_vld", 64'(btb_upd_vld_o), 0);

        // Back-to-back mispredicts: second is younger and suppressed
        drv(1, 6'd11, 30'h20, 0, 1, BT_COND, 32'h300, 0, 30'h0, BT_COND, 2'b00);
        exp_q.push_back(mk(0, 30'h20, 30'hC0, BT_COND, 2'b10));
        step();
        chk("t5a_excp", 64'(rcu_excp_o), 1);
        chk("t5a_rob", 64'(rcu_rob_o), 11);
        chk("t5a_redirect", 64'(rcu_redirect_o), 32'h300);
        drv(1, 6'd12, 30'h21, 0, 0, BT_JUMP, 32'h500, 0, 30'h0, BT_COND, 2'b00);
        step();
        chk("t5b_excp", 64'(rcu_excp_o), 0);
        chk("t5b_rob_hold", 64'(rcu_rob_o), 11);
        chk("t5b_redirect_hold", 64'(rcu_redirect_o), 32'h300);
        chk("t5b_no_push", 64'(btb_upd_vld_o), 0);
        idle(1'b1); step();
        flush_i = 1'b0;
        drv(1, 6'd13, 30'h22, 0, 0, BT_JUMP, 32'h600, 0, 30'h0, BT_COND, 2'b00);
        exp_q.push_back(mk(0, 30'h22, 30'h180, BT_JUMP, 2'b11));
        step();
        chk("t5c_excp", 64'(rcu_excp_o), 1);
        chk("t5c_rob", 64'(rcu_rob_o), 13);
        chk("t5c_redirect", 64'(rcu_redirect_o), 32'h600);
        idle(1'b1); step();
        idle(1'b0); step();

        // Back-pressure: two entries fill the queue, third is held off
        btb_upd_rdy_i = 1'b0;
        drv(1, 6'd14, 30'h30, 0, 1, BT_COND, 32'hC4, 1, 30'h31, BT_COND, 2'b10);
        exp_q.push_back(mk(0, 30'h30, 30'h31, BT_COND, 2'b11));
        step();
        chk("t6_stall1", 64'(stall_o), 0);
        chk("t6_excp1", 64'(rcu_excp_o), 0);
        drv(1, 6'd15, 30'h31, 0, 0, BT_COND, 32'hC8, 1, 30'h32, BT_COND, 2'b01);
        exp_q.push_back(mk(0, 30'h31, 30'h32, BT_COND, 2'b00));
        step();
        chk("t6_stall2", 64'(stall_o), 1);
        drv(1, 6'd16, 30'h32, 0, 1, BT_COND, 32'hD0, 1, 30'h34, BT_COND, 2'b10);
        step();
        chk("t6_stall3", 64'(stall_o), 1);
        chk("t6_head_vld", 64'(btb_upd_vld_o), 1);
        chk("t6_head_pc", 64'(btb_upd_pc_o), 30'h30);
        btb_upd_rdy_i = 1'b1;
        #1;
        chk("t6_stall_drop", 64'(stall_o), 0);
        exp_q.push_back(mk(0, 30'h32, 30'h34, BT_COND, 2'b11));
        step();
        chk("t6_stall_full_pop", 64'(stall_o), 0);
        idle(1'b0); step();
        step();
        chk("t6_drained", 64'(btb_upd_vld_o), 0);

        // AUIPC without a hit is not a branch event
        drv(1, 6'd17, 30'h3F, 1, 0, BT_COND, 32'h100, 0, 30'h0, BT_COND, 2'b00);
        step();
        chk("t7n_excp", 64'(rcu_excp_o), 0);
        chk("t7n_upd_vld", 64'(btb_upd_vld_o), 0);

        // AUIPC that hit in the BTB: redirect and invalidate the entry
        btb_upd_rdy_i = 1'b0;
        drv(1, 6'd18, 30'h40, 1, 0, BT_COND, 32'h104, 1, 30'h55, BT_COND, 2'b01);
        step();
        chk("t7_excp", 64'(rcu_excp_o), 1);
        chk("t7_rob", 64'(rcu_rob_o), 18);
        chk("t7_redirect", 64'(rcu_redirect_o), 32'h104);
        chk("t7_upd_vld", 64'(btb_upd_vld_o), 1);
        chk("t7_upd_inv", 64'(btb_upd_inv_o), 1);
        chk("t7_upd_pc", 64'(btb_upd_pc_o), 30'h40);
        chk("t7_upd_target", 64'(btb_upd_target_o), 30'h41);
        idle(1'b0); step();

        // Asynchronous reset while waiting for the flush
        rst = 1'b1;
        #1;
        chk("r_excp", 64'(rcu_excp_o), 0);
        chk("r_rob", 64'(rcu_rob_o), 0);
        chk("r_redirect", 64'(rcu_redirect_o), 0);
        chk("r_upd_vld", 64'(btb_upd_vld_o), 0);
        chk("r_upd_inv", 64'(btb_upd_inv_o), 0);
        chk("r_upd_pc", 64'(btb_upd_pc_o), 0);
        chk("r_stall", 64'(stall_o), 0);
        chk("r_call", 64'(call_affirm_o), 0);
        step();
        rst = 1'b0;
        btb_upd_rdy_i = 1'b1;

        // Reset left the stage idle: a new mispredict is reported without a flush
        drv(1, 6'd19, 30'h50, 0, 1, BT_COND, 32'h200, 0, 30'h0, BT_COND, 2'b00);
        exp_q.push_back(mk(0, 30'h50, 30'h80, BT_COND, 2'b10));
        step();
        chk("pr_excp", 64'(rcu_excp_o), 1);
        chk("pr_rob", 64'(rcu_rob_o), 19);
        chk("pr_redirect", 64'(rcu_redirect_o), 32'h200);
        idle(1'b1); step();
        idle(1'b0); step();
        chk("end_queue_empty", 64'(exp_q.size()), 0);
        chk("end_upd_vld", 64'(btb_upd_vld_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
